wbram_pingpong_sched: RTL

WBRAM_PINGPONG_SCHED -- requirements
Module: wbram_pingpong_sched

---
 rtl/wbram_pingpong_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/wbram_pingpong_sched.sv
// Ping-pong weight-buffer scheduler: hands two slots to a write controller,
// publishes filled slots to the read chain and recycles released slots.
module wbram_pingpong_sched #(
    parameter int MAX_NUM_LAYERS = 4,
    localparam int LW = $clog2(MAX_NUM_LAYERS) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [LW-1:0] num_layers_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [1:0]    wr_alloc_data_r,
    output logic [LW-1:0] wr_alloc_layer_r,
    output logic          wr_alloc_valid_r,
    input  logic          wr_alloc_ready_r,
    input  logic [1:0]    wr_done_data_l,
    input  logic          wr_done_valid_l,
    output logic          wr_done_ready_l,
    output logic [1:0]    wr_pointer_data_r,
    output logic          wr_pointer_valid_r,
    input  logic          wr_pointer_ready_r,
    input  logic [1:0]    rd_pointer_data_l,
    input  logic          rd_pointer_valid_l,
    output logic          rd_pointer_ready_l
);

    typedef enum logic [1:0] {
        S_FREE,
        S_FILLING,
        S_FULL,
        S_READING
    } slot_t;

    typedef enum logic {
        IDLE,
        RUN
    } fsm_t;

    localparam logic [LW-1:0] ONE = LW'(1);

    fsm_t          state_q;
    fsm_t          state_d;
    slot_t         slot_q [2];
    logic [LW-1:0] n_q;
    logic [LW-1:0] alloc_cnt;
    logic [LW-1:0] pub_cnt;
    logic [LW-1:0] rel_cnt;
    logic          next_alloc;
    logic          next_pub;
    logic          next_rel;

    logic alloc_hs;
    logic fill_hs;
    logic pub_hs;
    logic rel_hs;
    logic fill_ok;
    logic fill_bad;
    logic rel_ok;
    logic rel_bad;
    logic last_rel;
    logic start_run;
    logic start_zero;
    logic alloc_req;
    logic pub_req;

    assign busy_o             = (state_q == RUN);
    assign wr_done_ready_l    = busy_o;
    assign rd_pointer_ready_l = busy_o;

    always_comb begin
        alloc_hs   = wr_alloc_valid_r && wr_alloc_ready_r;
        fill_hs    = wr_done_valid_l && wr_done_ready_l;
        pub_hs     = wr_pointer_valid_r && wr_pointer_ready_r;
        rel_hs     = rd_pointer_valid_l && rd_pointer_ready_l;
        fill_ok    = fill_hs && !wr_done_data_l[1]
                     && (slot_q[wr_done_data_l[0]] == S_FILLING);
        fill_bad   = fill_hs && !fill_ok;
        // Releases must arrive in slot order; anything else is flagged.
        rel_ok     = rel_hs && (rd_pointer_data_l == {1'b0, next_rel})
                     && (slot_q[next_rel] == S_READING);
        rel_bad    = rel_hs && !rel_ok;
        last_rel   = rel_ok && ((rel_cnt + ONE) == n_q);
        start_run  = (state_q == IDLE) && start_i && (num_layers_i != '0);
        start_zero = (state_q == IDLE) && start_i && (num_layers_i == '0);
        alloc_req  = !wr_alloc_valid_r && (alloc_cnt < n_q)
                     && (slot_q[next_alloc] == S_FREE);
        pub_req    = !wr_pointer_valid_r && (pub_cnt < n_q)
                     && (slot_q[next_pub] == S_FULL);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_run) state_d = RUN;
            RUN:  if (last_rel) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0]          <= S_FREE;
            slot_q[1]          <= S_FREE;
            n_q                <= '0;
            alloc_cnt          <= '0;
            pub_cnt            <= '0;
            rel_cnt            <= '0;
            next_alloc         <= 1'b0;
            next_pub           <= 1'b0;
            next_rel           <= 1'b0;
            done_o             <= 1'b0;
            err_o              <= 1'b0;
            wr_alloc_data_r    <= '0;
            wr_alloc_layer_r   <= '0;
            wr_alloc_valid_r   <= 1'b0;
            wr_pointer_data_r  <= '0;
            wr_pointer_valid_r <= 1'b0;
        end else begin
            done_o <= start_zero || last_rel;
            if (fill_bad || rel_bad) err_o <= 1'b1;
            if (start_run) begin
                n_q        <= num_layers_i;
                alloc_cnt  <= '0;
                pub_cnt    <= '0;
                rel_cnt    <= '0;
                next_alloc <= 1'b0;
                next_pub   <= 1'b0;
                next_rel   <= 1'b0;
            end
            if (state_q == RUN) begin
                if (alloc_hs) begin
                    slot_q[next_alloc] <= S_FILLING;
                    alloc_cnt          <= alloc_cnt + ONE;
                    next_alloc         <= ~next_alloc;
                    wr_alloc_valid_r   <= 1'b0;
                end else if (alloc_req) begin
                    wr_alloc_valid_r <= 1'b1;
                    wr_alloc_data_r  <= {1'b0, next_alloc};
                    wr_alloc_layer_r <= alloc_cnt;
                end
                if (fill_ok) slot_q[wr_done_data_l[0]] <= S_FULL;
                if (pub_hs) begin
                    slot_q[next_pub]   <= S_READING;
                    pub_cnt            <= pub_cnt + ONE;
                    next_pub           <= ~next_pub;
                    wr_pointer_valid_r <= 1'b0;
                end else if (pub_req) begin
                    wr_pointer_valid_r <= 1'b1;
                    wr_pointer_data_r  <= {1'b0, next_pub};
                end
                if (rel_ok) begin
                    slot_q[next_rel] <= S_FREE;
                    rel_cnt          <= rel_cnt + ONE;
                    next_rel         <= ~next_rel;
                end
                // Run complete: leave every slot free for the next start.
                if (last_rel) begin
                    slot_q[0]          <= S_FREE;
                    slot_q[1]          <= S_FREE;
                    wr_alloc_valid_r   <= 1'b0;
                    wr_pointer_valid_r <= 1'b0;
                end
            end
        end
    end

endmodule
